// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALUOp codes, forwarding selects
// and the control bundle loaded when a bubble enters EX.
package id_ex_stage_pkg;

    localparam int ALUOP_W = 5;

    // ALUOp codes, matching the ctrl_encode_def encoding.
    localparam logic [ALUOP_W-1:0] ALUOP_NOP   = 5'b00000;
    localparam logic [ALUOP_W-1:0] ALUOP_LUI   = 5'b00001;
    localparam logic [ALUOP_W-1:0] ALUOP_AUIPC = 5'b00010;
    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 5'b00011;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 5'b00100;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic [ALUOP_W-1:0] aluop;
        logic               alusrc;
        logic               regwrite;
        logic               memread;
        logic               memwrite;
    } ex_ctrl_t;

    localparam ex_ctrl_t BUBBLE_CTRL = '{
        aluop:    ALUOP_NOP,
        alusrc:   1'b0,
        regwrite: 1'b0,
        memread:  1'b0,
        memwrite: 1'b0
    };

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Forwarding select for one EX source operand: EX/MEM beats MEM/WB,
// and x0 is never forwarded.
module id_ex_stage_fwd_unit
    import id_ex_stage_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] rs,
    input  logic            mem_regwrite,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            wb_regwrite,
    input  logic [RA_W-1:0] wb_rd,
    output logic [1:0]      sel
);

    // NOTE: every output of a combinational block gets a default first so no latch can be inferred.
    always_comb begin
        sel = FWD_NONE;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == rs)) begin
            sel = FWD_MEM;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush/stall
// handling and EX-side operand forwarding for the ALU.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [RA_W-1:0]    id_rs1,
    input  logic [RA_W-1:0]    id_rs2,
    input  logic               id_use_rs1,
    input  logic               id_use_rs2,
    input  logic [RA_W-1:0]    id_rd,
    input  logic [XLEN-1:0]    id_rdata1,
    input  logic [XLEN-1:0]    id_rdata2,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [ALUOP_W-1:0] id_aluop,
    input  logic               id_alusrc,
    input  logic               id_regwrite,
    input  logic               id_memread,
    input  logic               id_memwrite,
    input  logic               flush,
    input  logic               mem_stall,
    input  logic               mem_regwrite,
    input  logic [RA_W-1:0]    mem_rd,
    input  logic [XLEN-1:0]    mem_result,
    input  logic               wb_regwrite,
    input  logic [RA_W-1:0]    wb_rd,
    input  logic [XLEN-1:0]    wb_result,
    output logic               stall,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_pc,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic [RA_W-1:0]    ex_rd,
    output logic [XLEN-1:0]    ex_A,
    output logic [XLEN-1:0]    ex_B,
    output logic [XLEN-1:0]    ex_store_data,
    output logic               ex_regwrite,
    output logic               ex_memread,
    output logic               ex_memwrite
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] rdata1;
        logic [XLEN-1:0] rdata2;
        logic [XLEN-1:0] imm;
    } ex_data_t;

    logic     valid_q;
    ex_ctrl_t ctrl_q;
    ex_data_t data_q;
    ex_ctrl_t id_ctrl;
    ex_data_t id_data;
    logic     lu;
    logic [1:0] sel1;
    logic [1:0] sel2;
    logic [XLEN-1:0] fwd1;
    logic [XLEN-1:0] fwd2;

    // The regfile write in WB lands on the same edge as this capture, so take it directly.
    always_comb begin
        id_ctrl = '{aluop: id_aluop, alusrc: id_alusrc, regwrite: id_regwrite,
                    memread: id_memread, memwrite: id_memwrite};
        id_data = '{pc: id_pc, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                    rdata1: id_rdata1, rdata2: id_rdata2, imm: id_imm};
        if (wb_regwrite && (wb_rd != '0) && (wb_rd == id_rs1)) begin
            id_data.rdata1 = wb_result;
        end
        if (wb_regwrite && (wb_rd != '0) && (wb_rd == id_rs2)) begin
            id_data.rdata2 = wb_result;
        end
    end

    assign lu = valid_q && ctrl_q.memread && (data_q.rd != '0) && id_valid &&
                ((id_use_rs1 && (id_rs1 == data_q.rd)) ||
                 (id_use_rs2 && (id_rs2 == data_q.rd)));

    assign stall = lu || mem_stall;

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            ctrl_q  <= BUBBLE_CTRL;
            data_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
            ctrl_q  <= BUBBLE_CTRL;
            data_q  <= '0;
        end else if (mem_stall) begin
            valid_q <= valid_q;
        end else if (lu) begin
            valid_q <= 1'b0;
            ctrl_q  <= BUBBLE_CTRL;
            data_q  <= '0;
        end else begin
            valid_q <= id_valid;
            ctrl_q  <= id_ctrl;
            data_q  <= id_data;
        end
    end

    id_ex_stage_fwd_unit #(.RA_W(RA_W)) u_fwd1 (
        .rs           (data_q.rs1),
        .mem_regwrite (mem_regwrite),
        .mem_rd       (mem_rd),
        .wb_regwrite  (wb_regwrite),
        .wb_rd        (wb_rd),
        .sel          (sel1)
    );

    id_ex_stage_fwd_unit #(.RA_W(RA_W)) u_fwd2 (
        .rs           (data_q.rs2),
        .mem_regwrite (mem_regwrite),
        .mem_rd       (mem_rd),
        .wb_regwrite  (wb_regwrite),
        .wb_rd        (wb_rd),
        .sel          (sel2)
    );

    assign fwd1 = (sel1 == FWD_MEM) ? mem_result :
                  (sel1 == FWD_WB)  ? wb_result  : data_q.rdata1;
    assign fwd2 = (sel2 == FWD_MEM) ? mem_result :
                  (sel2 == FWD_WB)  ? wb_result  : data_q.rdata2;

    assign ex_valid      = valid_q;
    assign ex_pc         = data_q.pc;
    assign ex_aluop      = ctrl_q.aluop;
    assign ex_rd         = data_q.rd;
    assign ex_A          = fwd1;
    assign ex_B          = ctrl_q.alusrc ? data_q.imm : fwd2;
    assign ex_store_data = fwd2;
    assign ex_regwrite   = valid_q && ctrl_q.regwrite;
    assign ex_memread    = valid_q && ctrl_q.memread;
    assign ex_memwrite   = valid_q && ctrl_q.memwrite;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX-side operand delivery for the 5-stage RV32I pipeline; sits directly upstream of the EX-stage ALU and produces its A, B, ALUOp and PC inputs.
- Captures decoded fields from ID each cycle, detects load-use hazards and inserts bubbles, honours branch flush and downstream stall.
- Resolves EX/MEM and MEM/WB forwarding so the ALU always sees current operand values.

Parameters:
- XLEN, 32, datapath width
- RA_W, 5, register-index width

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of ID instruction
- id_rs1, id_rs2  in  RA_W each  source register indices
- id_use_rs1, id_use_rs2  in  1 each  instruction actually reads rs1/rs2
- id_rd  in  RA_W  destination index
- id_rdata1, id_rdata2  in  XLEN each  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_aluop  in  5  ALUOp code (ctrl_encode_def encoding)
- id_alusrc  in  1  1 = B takes immediate
- id_regwrite, id_memread, id_memwrite  in  1 each  decoded controls
- flush  in  1  branch/jump taken in EX; kill ID instruction
- mem_stall  in  1  downstream cannot accept; hold EX contents
- mem_regwrite  in  1  EX/MEM instruction writes rd
- mem_rd  in  RA_W;  mem_result  in  XLEN  EX/MEM forward source
- wb_regwrite  in  1;  wb_rd  in  RA_W;  wb_result  in  XLEN  MEM/WB forward source
- stall  out  1  ID/IF must hold (load-use or mem_stall)
- ex_valid  out  1  EX holds a real instruction
- ex_pc  out  XLEN;  ex_aluop  out  5;  ex_rd  out  RA_W
- ex_A, ex_B  out  XLEN each  ALU operands
- ex_store_data  out  XLEN  forwarded rs2 for stores
- ex_regwrite, ex_memread, ex_memwrite  out  1 each  controls, gated by ex_valid

Behaviour:
- Reset (rstn low, async): all registered state 0; ex_valid=0; ex_aluop=`ALUOp_nop; ex_pc=0; gated controls 0. After release, first capture occurs on the next rising edge.
- Load-use (combinational): lu = ex_valid & ex_memread & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)) & id_valid.
- stall = lu | mem_stall.
- Register update priority per edge:
  1. flush: load a bubble (ex_valid=0, aluop=nop, controls 0).
  2. else mem_stall: hold all state.
  3. else lu: load a bubble.
  4. else capture all id_* fields; ex_valid=id_valid.
- flush and lu together: bubble only; stall still asserted that cycle (ID is redirected anyway).
- WB bypass at capture: if wb_regwrite & wb_rd!=0 & wb_rd==id_rsN, the stored rdataN is wb_result, not id_rdataN (same-cycle regfile write).
- Forwarding (combinational, EX side) for fwdN:
  - mem_regwrite & mem_rd!=0 & mem_rd==ex_rsN -> mem_result
  - else wb_regwrite & wb_rd!=0 & wb_rd==ex_rsN -> wb_result
  - else stored rdataN
  - EX/MEM has priority over MEM/WB. x0 is never forwarded; it always reads 0 from stored data.
- ex_A = fwd1; ex_B = ex_alusrc ? ex_imm : fwd2; ex_store_data = fwd2 regardless of alusrc.
- Latency: ID inputs appear at EX outputs one cycle after the capturing edge; forwarding adds no cycles.
- Bubble held under mem_stall stays a bubble; a held valid instruction keeps re-evaluating forwarding each cycle.

Decomposition:
- Shared package/header (extend ctrl_encode_def.v): ALUOp codes (already there), FWD_NONE/FWD_MEM/FWD_WB select constants, bubble control defaults.
- One sub-module: fwd_unit (pure combinational; rs index, MEM/WB write info -> 2-bit select). Instantiated twice for rs1/rs2.

Test Plan:
- Reset mid-run: drive rstn low while ex_valid=1 -> immediately ex_valid=0, ex_aluop=nop, ex_regwrite=0, without waiting for a clock edge.
- Back-to-back ALU dependency: EX/MEM writes x5=0x0000_00A0; ID add x6,x5,x5 captured -> ex_A=ex_B=0x0000_00A0 via mem_result; stored rdata ignored.
- Double hazard: mem_rd=wb_rd=7, mem_result=1, wb_result=2, ex_rs1=7 -> ex_A=1 (MEM priority); with ex_rs1=0 -> ex_A=0.
- Load-use: EX lw x3, ID add x4,x3,x1 -> stall=1 for exactly one cycle, next EX is a bubble, following cycle the add is captured with x3 forwarded from MEM/WB.
- Flush during load-use: flush=1 and lu=1 same cycle -> bubble captured, ex_valid=0, no duplicate instruction afterwards.
- mem_stall hold for 3 cycles with id_* changing -> ex_pc and ex_rd unchanged; ex_A tracks a changing mem_result; on release the new ID instruction is captured.
